// File: rtl/axi_mem_slave_if.sv
// AXI4 bus bundle between a master and axi_mem_slave.
// The slave modport also carries the attributes the memory ignores.
interface axi_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 burst responder backed by an on-chip memory; independent read and
// write FSMs, one outstanding transaction per direction.
module axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int MEM_BYTES  = 4096
) (
  input  logic           clock_i,
  input  logic           reset_ni,
  axi_mem_slave_if.slave s_axi
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_BYTES) - BYTE_LSB;
  localparam int DEPTH    = MEM_BYTES / STRB_W;
  localparam logic [2:0] NATIVE_SIZE = 3'(BYTE_LSB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  function automatic addr_t next_addr(input addr_t a, input logic [7:0] len,
                                      input logic [1:0] burst);
    addr_t mask;
    mask = ((addr_t'(len) + addr_t'(1)) << BYTE_LSB) - addr_t'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + addr_t'(STRB_W)) & mask);
      default: next_addr = a + addr_t'(STRB_W);
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    burst_err = (size != NATIVE_SIZE) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
    word_idx = a[BYTE_LSB +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t            w_state, w_next;
  logic                awready_q, aw_hs, w_hs, w_final, mem_we;
  logic [ID_WIDTH-1:0] aw_id, bid_q;
  addr_t               aw_addr;
  logic [7:0]          aw_len, w_cnt;
  logic [1:0]          aw_burst, bresp_q;
  logic                aw_err, w_bad;

  r_state_t              r_state, r_next;
  logic                  arready_q, ar_hs, r_hs;
  logic [ID_WIDTH-1:0]   rid_q;
  addr_t                 r_addr;
  logic [7:0]            ar_len, r_cnt;
  logic [1:0]            ar_burst, rresp_q;
  logic                  ar_err, rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awregion,
                       s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.arregion};

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = (w_state == W_DATA);
  assign s_axi.bvalid  = (w_state == W_RESP);
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = (r_state == R_DATA);
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rlast   = rlast_q;

  // Write FSM: termination follows the beat count, wlast only affects bresp
  always_comb begin
    w_next  = w_state;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    w_final = 1'b0;
    case (w_state)
      W_IDLE: if (s_axi.awvalid && awready_q) begin
        aw_hs  = 1'b1;
        w_next = W_DATA;
      end
      W_DATA: if (s_axi.wvalid) begin
        w_hs = 1'b1;
        if (w_cnt == aw_len) begin
          w_final = 1'b1;
          w_next  = W_RESP;
        end
      end
      W_RESP: if (s_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      if (w_final) begin
        bid_q   <= aw_id;
        bresp_q <= (aw_err || w_bad || !s_axi.wlast) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (aw_hs) begin
      aw_id    <= s_axi.awid;
      aw_addr  <= s_axi.awaddr;
      aw_len   <= s_axi.awlen;
      aw_burst <= s_axi.awburst;
      aw_err   <= burst_err(s_axi.awsize, s_axi.awburst, s_axi.awlen);
      w_cnt    <= '0;
      w_bad    <= 1'b0;
    end else if (w_hs) begin
      aw_addr <= next_addr(aw_addr, aw_len, aw_burst);
      w_cnt   <= w_cnt + 8'd1;
      if (s_axi.wlast && !w_final) w_bad <= 1'b1;
    end
  end

  // A write landing during a reset edge is dropped along with the burst
  assign mem_we = w_hs && !aw_err && reset_ni;

  always_ff @(posedge clock_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[word_idx(aw_addr)][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM: rdata is prefetched from memory on each handshake
  always_comb begin
    r_next = r_state;
    ar_hs  = 1'b0;
    r_hs   = 1'b0;
    case (r_state)
      R_IDLE: if (s_axi.arvalid && arready_q) begin
        ar_hs  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: if (s_axi.rready) begin
        r_hs = 1'b1;
        if (rlast_q) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      if (ar_hs) begin
        rid_q   <= s_axi.arid;
        rresp_q <= burst_err(s_axi.arsize, s_axi.arburst, s_axi.arlen) ? RESP_SLVERR : RESP_OKAY;
        rlast_q <= (s_axi.arlen == 8'd0);
        rdata_q <= burst_err(s_axi.arsize, s_axi.arburst, s_axi.arlen)
                   ? '0 : mem[word_idx(s_axi.araddr)];
      end else if (r_hs && !rlast_q) begin
        rlast_q <= ((r_cnt + 8'd1) == ar_len);
        rdata_q <= ar_err ? '0 : mem[word_idx(r_addr)];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (ar_hs) begin
      ar_len   <= s_axi.arlen;
      ar_burst <= s_axi.arburst;
      ar_err   <= burst_err(s_axi.arsize, s_axi.arburst, s_axi.arlen);
      r_addr   <= next_addr(s_axi.araddr, s_axi.arlen, s_axi.arburst);
      r_cnt    <= '0;
    end else if (r_hs && !rlast_q) begin
      r_addr <= next_addr(r_addr, ar_len, ar_burst);
      r_cnt  <= r_cnt + 8'd1;
    end
  end
endmodule
